// File: rtl/dice_result_tracker_pkg.sv
// Shared definitions for the dice result tracker: FSM states, legal face
// range and the face-to-pip lookup used for the 7-LED display.
// Optional build macro: DICE_HIST_EN (per-face histogram, see top level).
package dice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLLING = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SHOW    = 2'd3
  } state_e;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  // Pip bit order: bit0 TL, bit1 TR, bit2 ML, bit3 C, bit4 MR, bit5 BL, bit6 BR.
  // Faces 0 and 7 are illegal and show nothing.
  localparam logic [6:0] PIP_TABLE [0:7] = '{
    7'b0000000,
    7'b0001000,
    7'b1000001,
    7'b1001001,
    7'b1100011,
    7'b1101011,
    7'b1110111,
    7'b0000000
  };

  function automatic logic [6:0] face_pips(input logic [2:0] face);
    return PIP_TABLE[face];
  endfunction

endpackage

// File: rtl/dice_result_tracker_if.sv
// Bus between the dice/board logic and the result tracker.
// Optional build macro: DICE_HIST_EN adds the histogram select/readout pair.
interface dice_result_tracker_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned SUM_W = 11
);

  logic             button;
  logic [2:0]       throw;
  logic             clear;
  logic [2:0]       result;
  logic             result_valid;
  logic             error;
  logic [6:0]       pips;
  logic [CNT_W-1:0] roll_count;
  logic [SUM_W-1:0] sum_out;
`ifdef DICE_HIST_EN
  logic [2:0]       hist_sel;
  logic [CNT_W-1:0] hist_count;
`endif

  modport master (
    output button, throw, clear,
`ifdef DICE_HIST_EN
    output hist_sel,
    input  hist_count,
`endif
    input  result, result_valid, error, pips, roll_count, sum_out
  );

  modport slave (
    input  button, throw, clear,
`ifdef DICE_HIST_EN
    input  hist_sel,
    output hist_count,
`endif
    output result, result_valid, error, pips, roll_count, sum_out
  );

endinterface

// File: rtl/dice_result_tracker_sat_counter.sv
// Saturating accumulator: adds `add` when inc is high, holds at all-ones,
// synchronous clear has priority over increment.
module dice_sat_counter #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [AW-1:0] add,
  output logic [W-1:0]  count
);

  localparam int unsigned EW = ((W > AW) ? W : AW) + 1;

  logic [W-1:0]  count_q, count_d;
  logic [EW-1:0] sum_ext;

  // Next count: clear, saturating add, or hold.
  always_comb begin
    sum_ext = EW'(count_q) + EW'(add);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (|sum_ext[EW-1:W]) count_d = '1;
      else                  count_d = sum_ext[W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/dice_result_tracker.sv
// Dice result tracker: detects button release, captures and validates the
// final face, drives the pip display (blinking after a capture), a one-cycle
// result strobe and saturating roll/sum statistics.
// Optional build macro: DICE_HIST_EN adds six per-face counters with a
// combinational readout selected by hist_sel.
module dice_result_tracker
  import dice_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned SUM_W     = 11,
  parameter int unsigned BLINK_CYC = 4
) (
  input logic                 clk,
  input logic                 rst,
  dice_result_tracker_if.slave bus
);

  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [2:0]    result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          error_q, error_d;
  logic [6:0]    pips_q, pips_d;

  logic legal;
  logic capture;
  logic cap_legal;

  assign legal     = (bus.throw >= FACE_MIN) && (bus.throw <= FACE_MAX);
  assign capture   = (state_q == ST_CAPTURE) && !bus.clear;
  assign cap_legal = capture && legal;

  // Next state and blink position; a press in IDLE or SHOW restarts a roll.
  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.button) state_d = ST_ROLLING;
      end
      ST_ROLLING: begin
        if (!bus.button) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_SHOW;
        blink_d = '0;
      end
      ST_SHOW: begin
        if (bus.button)                 state_d = ST_ROLLING;
        else if (blink_q == BLINK_LAST) state_d = ST_IDLE;
        else                            blink_d = blink_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result, strobe and sticky error; clear beats a coincident capture.
  always_comb begin
    result_d       = result_q;
    error_d        = error_q;
    result_valid_d = cap_legal;
    if (bus.clear) begin
      result_d = '0;
      error_d  = 1'b0;
    end else if (capture) begin
      if (legal) result_d = bus.throw;
      else       error_d  = 1'b1;
    end
  end

  // Pips are chosen from the upcoming state so that the registered display
  // lines up with it: first SHOW cycle blank, then alternating with the face.
  always_comb begin
    pips_d = '0;
    unique case (state_d)
      ST_ROLLING, ST_CAPTURE: pips_d = face_pips(bus.throw);
      ST_SHOW:                pips_d = blink_d[0] ? face_pips(result_d) : '0;
      default:                pips_d = face_pips(result_d);
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      blink_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      pips_q         <= '0;
    end else begin
      state_q        <= state_d;
      blink_q        <= blink_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      pips_q         <= pips_d;
    end
  end

  dice_sat_counter #(.W(CNT_W), .AW(1)) u_roll_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear),
    .inc   (cap_legal),
    .add   (1'b1),
    .count (bus.roll_count)
  );

  dice_sat_counter #(.W(SUM_W), .AW(3)) u_sum_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear),
    .inc   (cap_legal),
    .add   (bus.throw),
    .count (bus.sum_out)
  );

`ifdef DICE_HIST_EN
  logic [CNT_W-1:0] hist_cnt [6];
  logic [CNT_W-1:0] hist_rd;

  for (genvar g = 0; g < 6; g++) begin : g_hist
    dice_sat_counter #(.W(CNT_W), .AW(1)) u_hist_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clear),
      .inc   (cap_legal && (bus.throw == 3'(g + 1))),
      .add   (1'b1),
      .count (hist_cnt[g])
    );
  end

  // Histogram readout; faces 0 and 7 read as zero.
  always_comb begin
    hist_rd = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bus.hist_sel == 3'(i + 1)) hist_rd = hist_cnt[i];
    end
  end

  assign bus.hist_count = hist_rd;
`endif

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.error        = error_q;
  assign bus.pips         = pips_q;

endmodule

// File: tb/tb_dice_result_tracker.sv
// Directed bench for dice_result_tracker: a vector table for the main
// sequence plus hand-written async-reset and saturation sequences on a
// second, narrow-counter instance.
module tb_dice_result_tracker;

  localparam logic [6:0] P0 = 7'b0000000;
  localparam logic [6:0] P2 = 7'b1000001;
  localparam logic [6:0] P3 = 7'b1001001;
  localparam logic [6:0] P4 = 7'b1100011;
  localparam logic [6:0] P5 = 7'b1101011;
  localparam logic [6:0] P6 = 7'b1110111;
  localparam logic [6:0] P1 = 7'b0001000;

  logic clk;
  logic rst;

  dice_result_tracker_if #(.CNT_W(8), .SUM_W(11)) bus ();
  dice_result_tracker_if #(.CNT_W(2), .SUM_W(11)) sbus ();

  dice_result_tracker #(.CNT_W(8), .SUM_W(11), .BLINK_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  dice_result_tracker #(.CNT_W(2), .SUM_W(11), .BLINK_CYC(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        button;
    logic [2:0]  throw;
    logic        clear;
    logic [2:0]  e_result;
    logic        e_rv;
    logic        e_err;
    logic [6:0]  e_pips;
    logic [7:0]  e_roll;
    logic [10:0] e_sum;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input logic b, input logic [2:0] t, input logic c,
                     input logic [2:0] r, input logic rv, input logic e,
                     input logic [6:0] p, input logic [7:0] rc, input logic [10:0] s);
    vec_t v;
    v.button = b; v.throw = t; v.clear = c;
    v.e_result = r; v.e_rv = rv; v.e_err = e; v.e_pips = p;
    v.e_roll = rc; v.e_sum = s;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_main(input int idx, input vec_t v);
    n_vec++;
    if (bus.result !== v.e_result || bus.result_valid !== v.e_rv ||
        bus.error !== v.e_err || bus.pips !== v.e_pips ||
        bus.roll_count !== v.e_roll || bus.sum_out !== v.e_sum) begin
      n_bad++;
      $display("FAIL vec%0d: got res=%0d rv=%0b err=%0b pips=%b roll=%0d sum=%0d, expected res=%0d rv=%0b err=%0b pips=%b roll=%0d sum=%0d",
               idx, bus.result, bus.result_valid, bus.error, bus.pips, bus.roll_count, bus.sum_out,
               v.e_result, v.e_rv, v.e_err, v.e_pips, v.e_roll, v.e_sum);
    end
  endtask

  task automatic roll_small(input int k);
    int exp_cnt;
    exp_cnt = (k < 3) ? k : 3;
    sbus.button = 1'b1; sbus.throw = 3'd2; tick();
    sbus.button = 1'b0; sbus.throw = 3'd6; tick();
    tick();
    check_val($sformatf("sat%0d_rv", k), 32'(sbus.result_valid), 32'd1);
    check_val($sformatf("sat%0d_result", k), 32'(sbus.result), 32'd6);
    check_val($sformatf("sat%0d_roll", k), 32'(sbus.roll_count), 32'(exp_cnt));
    check_val($sformatf("sat%0d_sum", k), 32'(sbus.sum_out), 32'(6 * k));
    repeat (4) tick();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.button = 1'b0;  bus.throw = 3'd0;  bus.clear = 1'b0;
    sbus.button = 1'b0; sbus.throw = 3'd0; sbus.clear = 1'b0;
`ifdef DICE_HIST_EN
    bus.hist_sel = 3'd0;
    sbus.hist_sel = 3'd0;
`endif

    // Idle after reset.
    repeat (10) add(0, 0, 0, 0, 0, 0, P0, 0, 0);
    // Seven-cycle press, release on 5.
    add(1, 2, 0, 0, 0, 0, P2, 0, 0);
    add(1, 3, 0, 0, 0, 0, P3, 0, 0);
    add(1, 4, 0, 0, 0, 0, P4, 0, 0);
    add(1, 1, 0, 0, 0, 0, P1, 0, 0);
    add(1, 6, 0, 0, 0, 0, P6, 0, 0);
    add(1, 2, 0, 0, 0, 0, P2, 0, 0);
    add(1, 5, 0, 0, 0, 0, P5, 0, 0);
    add(0, 5, 0, 0, 0, 0, P5, 0, 0);
    add(0, 5, 0, 5, 1, 0, P0, 1, 5);
    add(0, 5, 0, 5, 0, 0, P5, 1, 5);
    add(0, 5, 0, 5, 0, 0, P0, 1, 5);
    add(0, 5, 0, 5, 0, 0, P5, 1, 5);
    add(0, 5, 0, 5, 0, 0, P5, 1, 5);
    add(0, 5, 0, 5, 0, 0, P5, 1, 5);
    // Illegal face 7 at release, then clear.
    add(1, 3, 0, 5, 0, 0, P3, 1, 5);
    add(0, 7, 0, 5, 0, 0, P0, 1, 5);
    add(0, 7, 0, 5, 0, 1, P0, 1, 5);
    add(0, 7, 0, 5, 0, 1, P5, 1, 5);
    add(0, 7, 1, 0, 0, 0, P0, 0, 0);
    add(0, 7, 0, 0, 0, 0, P0, 0, 0);
    add(0, 7, 0, 0, 0, 0, P0, 0, 0);
    // Roll 4, press again two cycles into SHOW, clear on the CAPTURE of 3.
    add(1, 4, 0, 0, 0, 0, P4, 0, 0);
    add(0, 4, 0, 0, 0, 0, P4, 0, 0);
    add(0, 4, 0, 4, 1, 0, P0, 1, 4);
    add(0, 4, 0, 4, 0, 0, P4, 1, 4);
    add(1, 2, 0, 4, 0, 0, P2, 1, 4);
    add(1, 6, 0, 4, 0, 0, P6, 1, 4);
    add(0, 3, 0, 4, 0, 0, P3, 1, 4);
    add(0, 3, 1, 0, 0, 0, P0, 0, 0);
    repeat (4) add(0, 3, 0, 0, 0, 0, P0, 0, 0);
    // One-cycle button glitch is a full roll.
    add(1, 6, 0, 0, 0, 0, P6, 0, 0);
    add(0, 6, 0, 0, 0, 0, P6, 0, 0);
    add(0, 6, 0, 6, 1, 0, P0, 1, 6);
    add(0, 6, 0, 6, 0, 0, P6, 1, 6);
    add(0, 6, 0, 6, 0, 0, P0, 1, 6);
    add(0, 6, 0, 6, 0, 0, P6, 1, 6);
    add(0, 6, 0, 6, 0, 0, P6, 1, 6);

    repeat (2) tick();
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      bus.button = vq[i].button;
      bus.throw  = vq[i].throw;
      bus.clear  = vq[i].clear;
      tick();
      check_main(i, vq[i]);
    end

`ifdef DICE_HIST_EN
    bus.hist_sel = 3'd6; #1;
    check_val("hist_main_6", 32'(bus.hist_count), 32'd1);
    bus.hist_sel = 3'd4; #1;
    check_val("hist_main_4", 32'(bus.hist_count), 32'd0);
    bus.hist_sel = 3'd7; #1;
    check_val("hist_main_7", 32'(bus.hist_count), 32'd0);
`endif

    // Asynchronous reset in the middle of a roll.
    bus.button = 1'b1; bus.throw = 3'd4; tick();
    check_val("pre_rst_pips", 32'(bus.pips), 32'(P4));
    #2 rst = 1'b1;
    #1;
    check_val("rst_pips", 32'(bus.pips), 32'(P0));
    check_val("rst_result", 32'(bus.result), 32'd0);
    check_val("rst_roll", 32'(bus.roll_count), 32'd0);
    check_val("rst_sum", 32'(bus.sum_out), 32'd0);
    bus.button = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_val("post_rst_idle_pips", 32'(bus.pips), 32'(P0));
    check_val("post_rst_rv", 32'(bus.result_valid), 32'd0);

    // Narrow counters: roll_count saturates at 3 while strobes continue.
    for (int k = 1; k <= 4; k++) roll_small(k);
`ifdef DICE_HIST_EN
    sbus.hist_sel = 3'd6; #1;
    check_val("hist_small_6", 32'(sbus.hist_count), 32'd3);
    sbus.hist_sel = 3'd0; #1;
    check_val("hist_small_0", 32'(sbus.hist_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
